stage_f_prefetch: RTL and testbench
===================================

// Module: stage_f_prefetch
// PURPOSE
//  Parametrised fetch stage for the dual-ISA (ARM/RV) pipeline. Holds the fetch PC, sequences it,
//  applies E/W-stage redirects, and buffers fetched instructions with their PCs in a DEPTH-entry
//  prefetch queue. Decode consumes the queue over a valid/ready handshake instead of a raw StallF.
//  Sits between the instruction memory port and stage_d.
// PARAMETERS
//  XLEN      32  PC / instruction width
//  IMEM_AW   13  instruction-memory word-address width (imem_A = PC[IMEM_AW+1:2])
//  DEPTH     4   prefetch queue entries, power of 2, >= 2
//  RESET_PC  0   PC value loaded on reset
// PORTS
//  clk           in   1        clock
//  rst           in   1        async reset, active-high
//  arm           in   1        1 = ARM redirect sources active, 0 = RV
//  RVPCSrcE      in   1        RV branch/jump taken in E
//  BranchTakenE  in   1        ARM branch taken in E
//  PCSrcW        in   1        ARM PC write in W
//  PCTargetE     in   XLEN     RV redirect target
//  ALUResultE    in   XLEN     ARM branch target
//  ResultW       in   XLEN     ARM W-stage PC value
//  FlushD        in   1        discard queued instructions
//  imem_A        out  IMEM_AW  instruction-memory word address (combinational read)
//  imem_RD       in   XLEN     instruction-memory data for imem_A, same cycle
//  ValidD        out  1        head entry valid
//  ReadyD        in   1        decode accepts head entry this cycle
//  RDD           out  XLEN     head instruction
//  PCD           out  XLEN     head PC
//  PCPlus4D      out  XLEN     head PC + 4
// BEHAVIOUR
//  Reset (async): PC=RESET_PC, queue empty, ValidD=0, RDD/PCD/PCPlus4D=0. All state is flops.
//  Redirect select, priority high->low: !arm&RVPCSrcE -> PCTargetE; arm&BranchTakenE -> ALUResultE;
//   arm&PCSrcW -> ResultW. redirect = any of the three.
//  Pop: ValidD & ReadyD. Push: !redirect & !FlushD & (count<DEPTH | pop); pushes {imem_RD, PC}.
//  PC next: redirect -> target; else FlushD -> rewind value; else push -> PC+4; else hold.
//  Redirect: whole queue cleared at the edge, push suppressed, ValidD=0 next cycle; a pop in the
//   same cycle still completes (decode sees its handshake), and is then squashed by the E-stage flush.
//  FlushD without redirect: queue cleared; PC rewound to the PC of the oldest entry (head),
//   or held if queue empty; no push that cycle.
//  Full (count==DEPTH) and no pop: PC holds, no push; imem_A is still driven from PC.
//  Full with pop: push and pop in the same cycle, count unchanged.
//  Empty: ValidD=0, RDD/PCD/PCPlus4D=0; ReadyD is ignored.
//  Latency: fetch at PC in cycle N -> head at ValidD in cycle N+1 (queue empty, no redirect).
//  Arithmetic: PC+4 and PCPlus4D wrap modulo 2^XLEN. PC[1:0] is kept as given and ignored by imem_A.
//  Pointers: log2(DEPTH)-bit read/write pointers wrap naturally; count is log2(DEPTH)+1 bits.
//  Reset asserted mid-operation: state returns to reset values immediately, with no partial pop.
// CONFIGURATION
//  STAGE_F_BYPASS_EN defined: when the queue is empty and there is no redirect/FlushD, the current
//   fetch is presented combinationally (ValidD=1, RDD=imem_RD, PCD=PC) in the same cycle. If
//   ReadyD=1 it is consumed, not enqueued, and PC advances; otherwise it is enqueued as normal.
//   Latency 0.
//  Not defined: the path is always through the queue; minimum latency 1 cycle.
// TESTING
//  1 Reset RESET_PC=0x100, ReadyD=1, imem_RD=word addr -> PCD 0x100,0x104,0x108 on consecutive
//    cycles with ValidD=1 from cycle 1 (cycle 0 with BYPASS).
//  2 ReadyD=0 for 10 cycles, DEPTH=4 -> exactly 4 pushes, PC stalls at RESET_PC+16; ReadyD=1 ->
//    entries drain in order 0x100..0x10C, then 0x110 follows without a bubble.
//  3 arm=0, RVPCSrcE=1, PCTargetE=0x2000 with 3 entries queued -> next cycle ValidD=0,
//    then PCD=0x2000.
//  4 arm=1, BranchTakenE=1 (ALUResultE=0x40) and PCSrcW=1 (ResultW=0x80) in the same cycle
//    -> PCD=0x40. arm=0 with the same inputs -> no redirect.
//  5 FlushD=1 alone with head PCD=0x108 -> queue empty, refetch resumes at 0x108.
//  6 PC=0xFFFFFFFC, sequential fetch -> PCPlus4D=0x0, next PCD=0x0; async rst pulse mid-burst
//    -> ValidD=0 in the same cycle.

Source files
------------

// File: rtl/stage_f_prefetch_if.sv
// Fetch-stage bus: instruction-memory read port plus the decode-side valid/ready queue head.
interface stage_f_prefetch_if #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned IMEM_AW = 13
);
    logic [IMEM_AW-1:0] imem_A;
    logic [XLEN-1:0]    imem_RD;
    logic               ValidD;
    logic               ReadyD;
    logic [XLEN-1:0]    RDD;
    logic [XLEN-1:0]    PCD;
    logic [XLEN-1:0]    PCPlus4D;

    modport master (
        output imem_A, ValidD, RDD, PCD, PCPlus4D,
        input  imem_RD, ReadyD
    );

    modport slave (
        input  imem_A, ValidD, RDD, PCD, PCPlus4D,
        output imem_RD, ReadyD
    );
endinterface

// File: rtl/stage_f_prefetch.sv
// Fetch stage: PC sequencing, E/W redirects and a DEPTH-entry prefetch queue feeding decode.
// Optional STAGE_F_BYPASS_EN presents the current fetch straight to decode when the queue is empty.
module stage_f_prefetch #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     IMEM_AW  = 13,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arm,
    input  logic                 RVPCSrcE,
    input  logic                 BranchTakenE,
    input  logic                 PCSrcW,
    input  logic [XLEN-1:0]      PCTargetE,
    input  logic [XLEN-1:0]      ALUResultE,
    input  logic [XLEN-1:0]      ResultW,
    input  logic                 FlushD,
    stage_f_prefetch_if.master   f_if
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];

    logic            redirect;
    logic [XLEN-1:0] target;
    logic            empty, full, valid, pop, push, bypass, consume;
    entry_t          head, fetch_e, out_e;

    // Redirect priority: RV E-stage, then ARM E-stage branch, then ARM W-stage PC write.
    always_comb begin
        redirect = 1'b0;
        target   = ResultW;
        if (!arm && RVPCSrcE) begin
            redirect = 1'b1;
            target   = PCTargetE;
        end else if (arm && BranchTakenE) begin
            redirect = 1'b1;
            target   = ALUResultE;
        end else if (arm && PCSrcW) begin
            redirect = 1'b1;
        end
    end

    always_comb begin
        empty   = (count_q == CW'(0));
        full    = (count_q == CW'(DEPTH));
        head    = mem_q[rd_ptr_q];
        fetch_e = '{instr: f_if.imem_RD, pc: pc_q};
`ifdef STAGE_F_BYPASS_EN
        bypass  = empty && !redirect && !FlushD;
`else
        bypass  = 1'b0;
`endif
        valid   = !empty || bypass;
        out_e   = empty ? fetch_e : head;
        pop     = !empty && f_if.ReadyD;
        consume = bypass && f_if.ReadyD;
        // A bypassed fetch taken by decode never enters the queue.
        push    = !redirect && !FlushD && (!full || pop) && !consume;
    end

    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (redirect) begin
            pc_d     = target;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (FlushD) begin
            // Refetch from the oldest discarded instruction so nothing is skipped.
            pc_d     = empty ? pc_q : head.pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = fetch_e;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push || consume) begin
                pc_d = pc_q + XLEN'(4);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '{default: '0};
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign f_if.imem_A   = pc_q[IMEM_AW+1:2];
    assign f_if.ValidD   = valid;
    assign f_if.RDD      = valid ? out_e.instr : '0;
    assign f_if.PCD      = valid ? out_e.pc : '0;
    assign f_if.PCPlus4D = valid ? (out_e.pc + XLEN'(4)) : '0;
endmodule

// File: tb/tb_stage_f_prefetch.sv
// Directed bench for stage_f_prefetch (default build, queue latency 1, DEPTH=4, RESET_PC=0x100).
module tb_stage_f_prefetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        arm, RVPCSrcE, BranchTakenE, PCSrcW, FlushD;
    logic [31:0] PCTargetE, ALUResultE, ResultW;
    int          n_checks = 0;
    int          n_fail   = 0;

    stage_f_prefetch_if #(.XLEN(32), .IMEM_AW(13)) bus ();

    stage_f_prefetch #(
        .XLEN(32), .IMEM_AW(13), .DEPTH(4), .RESET_PC(32'h0000_0100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .arm          (arm),
        .RVPCSrcE     (RVPCSrcE),
        .BranchTakenE (BranchTakenE),
        .PCSrcW       (PCSrcW),
        .PCTargetE    (PCTargetE),
        .ALUResultE   (ALUResultE),
        .ResultW      (ResultW),
        .FlushD       (FlushD),
        .f_if         (bus)
    );

    // Instruction memory returns its own word address.
    assign bus.imem_RD = 32'(bus.imem_A);

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        arm = 1'b0; RVPCSrcE = 1'b0; BranchTakenE = 1'b0; PCSrcW = 1'b0; FlushD = 1'b0;
        PCTargetE = '0; ALUResultE = '0; ResultW = '0;
    endtask

    task automatic do_reset(input logic rdy);
        idle_inputs();
        bus.ReadyD = rdy;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        idle_inputs();
        bus.ReadyD = 1'b1;
        rst = 1'b1;
        #3;
        check("rst_valid", 32'(bus.ValidD), 32'd0);
        check("rst_rdd", bus.RDD, 32'd0);
        check("rst_pcd", bus.PCD, 32'd0);
        check("rst_pcp4", bus.PCPlus4D, 32'd0);
        check("rst_imem_a", 32'(bus.imem_A), 32'h40);

        // 1: sequential fetch with decode always ready
        do_reset(1'b1);
        check("t1_c0_valid", 32'(bus.ValidD), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t1_valid", 32'(bus.ValidD), 32'd1);
            check("t1_pcd", bus.PCD, 32'h100 + 32'(4 * i));
            check("t1_rdd", bus.RDD, 32'h40 + 32'(i));
        end
        check("t1_pcp4", bus.PCPlus4D, 32'h10C);

        // 2: fill while stalled, then drain in order without a bubble
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) tick();
        check("t2_stall_pc", 32'(bus.imem_A), 32'h44);
        bus.ReadyD = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("t2_drain_valid", 32'(bus.ValidD), 32'd1);
            check("t2_drain_pcd", bus.PCD, 32'h100 + 32'(4 * i));
            tick();
        end

        // 3: RV redirect with three entries queued
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) tick();
        check("t3_pre_pcd", bus.PCD, 32'h100);
        RVPCSrcE = 1'b1; PCTargetE = 32'h2000;
        tick();
        idle_inputs();
        #1;
        check("t3_bubble", 32'(bus.ValidD), 32'd0);
        check("t3_imem_a", 32'(bus.imem_A), 32'h800);
        tick();
        check("t3_valid", 32'(bus.ValidD), 32'd1);
        check("t3_pcd", bus.PCD, 32'h2000);
        check("t3_rdd", bus.RDD, 32'h800);

        // 4: ARM branch beats W-stage PC write; same inputs in RV mode do nothing
        do_reset(1'b0);
        arm = 1'b1; BranchTakenE = 1'b1; ALUResultE = 32'h40; PCSrcW = 1'b1; ResultW = 32'h80;
        tick();
        idle_inputs();
        #1;
        check("t4_bubble", 32'(bus.ValidD), 32'd0);
        tick();
        check("t4_pcd", bus.PCD, 32'h40);
        do_reset(1'b0);
        arm = 1'b0; BranchTakenE = 1'b1; ALUResultE = 32'h40; PCSrcW = 1'b1; ResultW = 32'h80;
        tick();
        check("t4_rv_valid", 32'(bus.ValidD), 32'd1);
        check("t4_rv_pcd", bus.PCD, 32'h100);
        check("t4_rv_imem_a", 32'(bus.imem_A), 32'h41);
        idle_inputs();

        // 5: decode flush rewinds to the head PC
        do_reset(1'b1);
        for (int i = 0; i < 3; i++) tick();
        bus.ReadyD = 1'b0;
        tick();
        tick();
        check("t5_pre_pcd", bus.PCD, 32'h108);
        check("t5_pre_pc", 32'(bus.imem_A), 32'h45);
        FlushD = 1'b1;
        tick();
        FlushD = 1'b0;
        #1;
        check("t5_empty", 32'(bus.ValidD), 32'd0);
        check("t5_rewind", 32'(bus.imem_A), 32'h42);
        tick();
        check("t5_pcd", bus.PCD, 32'h108);

        // 6: PC wraps at 2^32, then async reset mid-burst
        do_reset(1'b0);
        RVPCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
        tick();
        idle_inputs();
        bus.ReadyD = 1'b1;
        tick();
        check("t6_top_pcd", bus.PCD, 32'hFFFF_FFFC);
        check("t6_wrap_pcp4", bus.PCPlus4D, 32'h0);
        check("t6_top_rdd", bus.RDD, 32'h1FFF);
        tick();
        check("t6_wrap_pcd", bus.PCD, 32'h0);
        tick();
        check("t6_next_pcd", bus.PCD, 32'h4);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 32'(bus.ValidD), 32'd0);
        check("t6_rst_pcd", bus.PCD, 32'd0);
        check("t6_rst_imem_a", 32'(bus.imem_A), 32'h40);
        tick();
        rst = 1'b0;
        #1;
        check("t6_post_rst_valid", 32'(bus.ValidD), 32'd0);
        tick();
        check("t6_post_rst_pcd", bus.PCD, 32'h100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
